// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge and samples each
// bit at its midpoint, delivering bytes with a one-cycle valid strobe.
module uart_rx_frame #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam logic [24:0] BIT_TERM  = 25'(BIT_CNT - 1);
    localparam logic [24:0] HALF_TERM = 25'(HALF_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_nx;
    logic        rx_meta, rx_s, rx_d;
    logic [24:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, idx_nx;
    logic [7:0]  shreg, sh_nx;
    logic [7:0]  data_nx;
    logic        valid_nx, ferr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= idx_nx;
            shreg     <= sh_nx;
            data      <= data_nx;
            valid     <= valid_nx;
            frame_err <= ferr_nx;
        end
    end

    // Counter defaults to clearing; it only advances while a bit interval is in progress.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        idx_nx   = bit_idx;
        sh_nx    = shreg;
        data_nx  = data;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_d && !rx_s) state_nx = START;
            end
            START: begin
                if (cnt >= HALF_TERM) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        idx_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 25'd1;
                end
            end
            DATA: begin
                if (cnt >= BIT_TERM) begin
                    sh_nx  = {rx_s, shreg[7:1]};
                    idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end else begin
                    cnt_nx = cnt + 25'd1;
                end
            end
            STOP: begin
                if (cnt >= BIT_TERM) begin
                    if (rx_s) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                    end else begin
                        ferr_nx = 1'b1;
                    end
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 25'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at 16 clocks per bit: directed scenarios plus random
// frames, checked against an arithmetic model of frame timing and contents.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx_frame #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    bit  both_high = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (valid && frame_err) both_high = 1'b1;
        if (valid) begin
            e.cyc = cyc; e.err = 1'b0; e.d = data;
            obs_q.push_back(e);
        end
        if (frame_err) begin
            e.cyc = cyc; e.err = 1'b1; e.d = data;
            obs_q.push_back(e);
        end
    end

    int         total = 0;
    int         bad = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a frame whose start falls at cycle f produces its event at f+3+8+9*16.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        ev_t e;
        int  f;
        rx = 1'b0;
        f  = cyc;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = stop_ok;
        tick(16);
        if (!stop_ok && hold_low > 0) tick(hold_low);
        e.cyc = f + 155;
        e.err = !stop_ok;
        e.d   = stop_ok ? b : last_good;
        if (stop_ok) last_good = b;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, ".count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s.err%0d", tag, i), {31'd0, obs_q[i].err}, {31'd0, exp_q[i].err});
            chk($sformatf("%s.data%0d", tag, i), {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int gf;
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("rst.data", {24'd0, data}, 32'h00);
        chk("rst.valid", {31'd0, valid}, 0);
        chk("rst.ferr", {31'd0, frame_err}, 0);
        chk("rst.busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        tick(5);

        // Reset in the middle of a frame
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(30);
        chk("abort.busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("abort.data", {24'd0, data}, 32'h00);
        chk("abort.valid", {31'd0, valid}, 0);
        chk("abort.ferr", {31'd0, frame_err}, 0);
        chk("abort.busy", {31'd0, busy}, 0);
        chk("abort.events", obs_q.size(), 0);
        obs_q.delete();
        last_good = 8'h00;
        tick(20);
        send_frame(8'h3C, 1'b1, 0);
        tick(10);
        check_events("f3C");

        send_frame(8'h55, 1'b1, 0);
        tick(10);
        check_events("f55");
        chk("f55.data_hold", {24'd0, data}, 32'h55);

        send_frame(8'hA3, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        tick(10);
        if (obs_q.size() == 2) chk("b2b.spacing", obs_q[1].cyc - obs_q[0].cyc, 160);
        check_events("b2b");

        // Glitch: 4-cycle low pulse is rejected at mid-start
        gf = cyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        chk("glitch.busy_high", {31'd0, busy}, 1);
        tick(6);
        chk("glitch.busy_low", {31'd0, busy}, 0);
        chk("glitch.elapsed", cyc - gf, 12);
        tick(10);
        check_events("glitch");
        send_frame(8'h7E, 1'b1, 0);
        tick(10);
        check_events("f7E");

        // Framing error, line then stuck low
        send_frame(8'hFF, 1'b0, 32);
        chk("ferr.busy_stuck_low", {31'd0, busy}, 0);
        chk("ferr.data_kept", {24'd0, data}, 32'h7E);
        check_events("ferr");
        rx = 1'b1;
        tick(8);
        send_frame(8'hC5, 1'b1, 0);
        tick(10);
        check_events("after_ferr");

        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 20)));
            if (!ok) begin
                rx = 1'b1;
                tick(4 + int'($urandom_range(0, 10)));
            end else if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, 30)));
            end
        end
        tick(10);
        check_events("rand");
        chk("final.data", {24'd0, data}, {24'd0, last_good});
        chk("never_both", {31'd0, both_high}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
